// File: rtl/axi_lite_clint_slave.sv
// Core-local interruptor on a 32-bit AXI4-Lite target port.
// Holds MSIP, the 64-bit MTIMECMP compare value and a free-running 64-bit
// MTIME counter. Drives the machine timer and software interrupt lines.
module axi_lite_clint_slave #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        S_AXI_ACLK,
    input  logic        S_AXI_ARESETN,
    input  logic [31:0] S_AXI_AWADDR,
    input  logic [2:0]  S_AXI_AWPROT,
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,
    input  logic [31:0] S_AXI_WDATA,
    input  logic [3:0]  S_AXI_WSTRB,
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,
    output logic [1:0]  S_AXI_BRESP,
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY,
    input  logic [31:0] S_AXI_ARADDR,
    input  logic [2:0]  S_AXI_ARPROT,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    output logic [31:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY,
    output logic        TIMER_IRQ,
    output logic        SOFT_IRQ
);

    typedef enum logic { W_IDLE, W_RESP } wr_state_t;
    typedef enum logic { R_IDLE, R_DATA } rd_state_t;
    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_MSIP,
        SEL_CMP_LO,
        SEL_CMP_HI,
        SEL_TIME_LO,
        SEL_TIME_HI
    } reg_sel_t;

    localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);
    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    // Word offset (address bits [15:2]) to register select.
    function automatic reg_sel_t decode(input logic [13:0] word);
        case (word)
            14'h0000: decode = SEL_MSIP;
            14'h1000: decode = SEL_CMP_LO;
            14'h1001: decode = SEL_CMP_HI;
            14'h2FFE: decode = SEL_TIME_LO;
            14'h2FFF: decode = SEL_TIME_HI;
            default:  decode = SEL_NONE;
        endcase
    endfunction

    // Byte-enable merge of new write data over the current word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                                input logic [31:0] data,
                                                input logic [3:0]  strb);
        merge_bytes = cur;
        for (int unsigned i = 0; i < 4; i++) begin
            if (strb[i]) begin
                merge_bytes[8*i +: 8] = data[8*i +: 8];
            end
        end
    endfunction

    // Register state
    logic        out_en;
    logic        msip;
    logic [63:0] mtimecmp;
    logic [63:0] mtime;
    logic [15:0] prescaler;
    logic        tick;

    // Write channel state
    wr_state_t   wr_state, wr_state_nx;
    logic        aw_held, w_held;
    logic [13:0] awaddr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [1:0]  bresp_q;
    logic        aw_hs, w_hs, wr_fire;
    logic [13:0] wr_word;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    reg_sel_t    wr_sel;

    // Read channel state
    rd_state_t   rd_state, rd_state_nx;
    logic        ar_hs;
    logic [31:0] rdata_q, rd_val;
    logic [1:0]  rresp_q;
    logic        rd_err;

    logic        unused_bits;
    assign unused_bits = ^{S_AXI_AWADDR[31:16], S_AXI_AWADDR[1:0],
                           S_AXI_ARADDR[31:16], S_AXI_ARADDR[1:0],
                           S_AXI_AWPROT, S_AXI_ARPROT};

    assign S_AXI_AWREADY = out_en & (wr_state == W_IDLE) & ~aw_held;
    assign S_AXI_WREADY  = out_en & (wr_state == W_IDLE) & ~w_held;
    assign S_AXI_BVALID  = (wr_state == W_RESP);
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = out_en & (rd_state == R_IDLE);
    assign S_AXI_RVALID  = (rd_state == R_DATA);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign SOFT_IRQ      = msip;

    assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;
    assign tick  = (prescaler == PRESC_LAST);

    // Ready outputs stay low during reset and rise on the first clock after release.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) out_en <= 1'b0;
        else                out_en <= 1'b1;
    end

    // Effective write transaction: held halves, or halves arriving on this edge.
    always_comb begin
        wr_word = aw_held ? awaddr_q : S_AXI_AWADDR[15:2];
        wr_data = w_held  ? wdata_q  : S_AXI_WDATA;
        wr_strb = w_held  ? wstrb_q  : S_AXI_WSTRB;
        wr_sel  = decode(wr_word);
        wr_fire = (wr_state == W_IDLE) & (aw_held | aw_hs) & (w_held | w_hs);
    end

    // Write FSM state register.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) wr_state <= W_IDLE;
        else                wr_state <= wr_state_nx;
    end

    // Write FSM next state: commit when both halves present, return on B handshake.
    always_comb begin
        wr_state_nx = wr_state;
        case (wr_state)
            W_IDLE:  if (wr_fire) wr_state_nx = W_RESP;
            W_RESP:  if (S_AXI_BREADY) wr_state_nx = W_IDLE;
            default: wr_state_nx = W_IDLE;
        endcase
    end

    // Capture AW/W halves independently; release both on the B handshake.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bresp_q  <= '0;
        end else begin
            if (wr_state == W_RESP && S_AXI_BREADY) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end else begin
                if (aw_hs) begin
                    aw_held  <= 1'b1;
                    awaddr_q <= S_AXI_AWADDR[15:2];
                end
                if (w_hs) begin
                    w_held  <= 1'b1;
                    wdata_q <= S_AXI_WDATA;
                    wstrb_q <= S_AXI_WSTRB;
                end
            end
            if (wr_fire) begin
                bresp_q <= (wr_sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // MSIP and MTIMECMP software-visible registers.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            msip     <= 1'b0;
            mtimecmp <= '1;
        end else if (wr_fire) begin
            if (wr_sel == SEL_MSIP && wr_strb[0]) begin
                msip <= wr_data[0];
            end
            if (wr_sel == SEL_CMP_LO) begin
                mtimecmp[31:0] <= merge_bytes(mtimecmp[31:0], wr_data, wr_strb);
            end
            if (wr_sel == SEL_CMP_HI) begin
                mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], wr_data, wr_strb);
            end
        end
    end

    // Prescaled MTIME counter; a bus write to either half wins over the tick.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            mtime     <= '0;
            prescaler <= '0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 16'd1;
            if (wr_fire && wr_sel == SEL_TIME_LO) begin
                mtime[31:0] <= merge_bytes(mtime[31:0], wr_data, wr_strb);
            end else if (wr_fire && wr_sel == SEL_TIME_HI) begin
                mtime[63:32] <= merge_bytes(mtime[63:32], wr_data, wr_strb);
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end
        end
    end

    // Timer interrupt registered from the current compare.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) TIMER_IRQ <= 1'b0;
        else                TIMER_IRQ <= (mtime >= mtimecmp);
    end

    // Read data mux over the current register values.
    always_comb begin
        rd_val = '0;
        rd_err = 1'b0;
        case (decode(S_AXI_ARADDR[15:2]))
            SEL_MSIP:    rd_val = {31'b0, msip};
            SEL_CMP_LO:  rd_val = mtimecmp[31:0];
            SEL_CMP_HI:  rd_val = mtimecmp[63:32];
            SEL_TIME_LO: rd_val = mtime[31:0];
            SEL_TIME_HI: rd_val = mtime[63:32];
            default:     rd_err = 1'b1;
        endcase
    end

    // Read FSM state register.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) rd_state <= R_IDLE;
        else                rd_state <= rd_state_nx;
    end

    // Read FSM next state: data phase after AR handshake, back on R handshake.
    always_comb begin
        rd_state_nx = rd_state;
        case (rd_state)
            R_IDLE:  if (ar_hs) rd_state_nx = R_DATA;
            R_DATA:  if (S_AXI_RREADY) rd_state_nx = R_IDLE;
            default: rd_state_nx = R_IDLE;
        endcase
    end

    // Latch read data and response on the AR handshake; held until consumed.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rdata_q <= '0;
            rresp_q <= '0;
        end else if (ar_hs) begin
            rdata_q <= rd_val;
            rresp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
        end
    end

endmodule
